// File: rtl/int_inj_pkg.sv
// Shared types and constants for the interrupt injector.
// The optional ack timeout (INT_INJ_TIMEOUT_EN) is handled in int_injector.sv.
package int_inj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } inj_state_e;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7F20;
  localparam logic [31:0] PC_MASK          = 32'hFFFF_FFFC;

  localparam int FIRE_W = 8;
  localparam int SLOT_W = 4;
  localparam int CNT_W  = 4;
  localparam int COOL_W = 8;

endpackage

// File: rtl/int_trig_match.sv
// Compares the word-aligned PC against every slot that still has firings left
// and reports the lowest-index hit.
module int_trig_match
  import int_inj_pkg::*;
#(
  parameter int                     NUM_TRIG = 4,
  parameter logic [NUM_TRIG*32-1:0] TRIG_PCS = {NUM_TRIG{32'h0000_302C}}
) (
  input  logic [31:0]               pc_i,
  input  logic [NUM_TRIG*CNT_W-1:0] remaining_i,
  output logic                      hit_o,
  output logic [SLOT_W-1:0]         winner_o
);

  // Scan high to low so the lowest matching index is the last assignment.
  always_comb begin
    hit_o    = 1'b0;
    winner_o = '0;
    for (int k = NUM_TRIG - 1; k >= 0; k--) begin
      if (((pc_i & PC_MASK) == TRIG_PCS[k*32 +: 32]) &&
          (remaining_i[k*CNT_W +: CNT_W] != '0)) begin
        hit_o    = 1'b1;
        winner_o = SLOT_W'(k);
      end
    end
  end

endmodule

// File: rtl/int_injector.sv
// PC-triggered interrupt generator for CPU benches: IDLE -> ASSERT -> COOLDOWN.
// Define INT_INJ_TIMEOUT_EN to add ACK_TIMEOUT and the sticky timeout_err output.
module int_injector
  import int_inj_pkg::*;
#(
  parameter int                        NUM_TRIG   = 4,
  parameter logic [NUM_TRIG*32-1:0]    TRIG_PCS   = {NUM_TRIG{32'h0000_302C}},
  parameter logic [NUM_TRIG*CNT_W-1:0] TRIG_CNT   = {NUM_TRIG{4'd1}},
  parameter logic [31:0]               ACK_ADDR   = ACK_ADDR_DEFAULT,
  parameter int                        PULSE_MODE = 0,
  parameter int                        COOLDOWN   = 2
`ifdef INT_INJ_TIMEOUT_EN
  ,
  parameter int                        ACK_TIMEOUT = 1024
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       macroscopic_pc,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  output logic              interrupt,
  output logic [FIRE_W-1:0] fire_count,
  output logic [SLOT_W-1:0] active_slot,
  output logic [1:0]        dbg_state
`ifdef INT_INJ_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  // Entering COOLDOWN loads COOLDOWN-1 so the state lasts exactly COOLDOWN cycles.
  localparam logic [COOL_W-1:0] COOL_LOAD = (COOLDOWN == 0) ? '0 : COOL_W'(COOLDOWN - 1);

  inj_state_e                state_q, state_d;
  logic [COOL_W-1:0]         cool_q, cool_d;
  logic [FIRE_W-1:0]         fire_q, fire_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [NUM_TRIG*CNT_W-1:0] rem_q, rem_d;

  logic              hit;
  logic [SLOT_W-1:0] winner;
  logic              ack;
  logic              timeout;
  logic              take;

  int_trig_match #(
    .NUM_TRIG (NUM_TRIG),
    .TRIG_PCS (TRIG_PCS)
  ) u_match (
    .pc_i        (macroscopic_pc),
    .remaining_i (rem_q),
    .hit_o       (hit),
    .winner_o    (winner)
  );

  assign ack  = (|m_int_byteen) && ((m_int_addr & PC_MASK) == ACK_ADDR);
  assign take = (state_q == ST_IDLE) && hit;

`ifdef INT_INJ_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            terr_q, terr_d;

  assign timeout = (PULSE_MODE == 0) && (state_q == ST_ASSERT) &&
                   (to_q == TO_W'(ACK_TIMEOUT - 1));
  assign to_d    = (state_q == ST_ASSERT) ? to_q + 1'b1 : '0;
  // An ack arriving on the final cycle counts as a proper release, not an error.
  assign terr_d  = terr_q | (timeout && !ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      to_q   <= to_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cool_q  <= '0;
      fire_q  <= '0;
      slot_q  <= '0;
      rem_q   <= TRIG_CNT;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      fire_q  <= fire_d;
      slot_q  <= slot_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ASSERT;
      ST_ASSERT: begin
        if ((PULSE_MODE != 0) || ack || timeout)
          state_d = (COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;
      end
      ST_COOLDOWN: if (cool_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cool_d = cool_q;
    fire_d = fire_q;
    slot_d = slot_q;
    rem_d  = rem_q;
    if ((state_q == ST_ASSERT) && (state_d == ST_COOLDOWN)) begin
      cool_d = COOL_LOAD;
    end else if ((state_q == ST_COOLDOWN) && (cool_q != '0)) begin
      cool_d = cool_q - 1'b1;
    end
    if (take) begin
      slot_d = winner;
      rem_d[winner*CNT_W +: CNT_W] = rem_q[winner*CNT_W +: CNT_W] - 1'b1;
      if (fire_q != '1) fire_d = fire_q + 1'b1;
    end
  end

  always_comb begin
    interrupt   = (state_q == ST_ASSERT);
    fire_count  = fire_q;
    active_slot = slot_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_int_injector.sv
// Directed bench for int_injector: several configurations side by side, one task
// per scenario, each checking its own hand-computed expectations.
module tb_int_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m_int_addr = '0;
  logic [3:0]  m_int_byteen = '0;
  logic [31:0] pc_a = '0, pc_b = '0, pc_c = '0, pc_d = '0, pc_e = '0;
  logic        int_a, int_b, int_c, int_d, int_e;
  logic [7:0]  fc_a, fc_b, fc_c, fc_d, fc_e;
  logic [3:0]  as_a, as_b, as_c, as_d, as_e;
  logic [1:0]  st_a, st_b, st_c, st_d, st_e;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: single slot at 0x302C fired once, level mode.
  int_injector #(.NUM_TRIG(1), .TRIG_PCS(32'h0000_302C), .TRIG_CNT(4'd1)) u_a (
    .clk(clk), .reset(reset), .macroscopic_pc(pc_a), .m_int_addr(m_int_addr),
    .m_int_byteen(m_int_byteen), .interrupt(int_a), .fire_count(fc_a),
    .active_slot(as_a), .dbg_state(st_a)
`ifdef INT_INJ_TIMEOUT_EN
    , .timeout_err()
`endif
  );

  // B: slot 0 at 0x3010, slot 1 at 0x3020, two firings each.
  int_injector #(.NUM_TRIG(2), .TRIG_PCS({32'h0000_3020, 32'h0000_3010}),
                 .TRIG_CNT({4'd2, 4'd2})) u_b (
    .clk(clk), .reset(reset), .macroscopic_pc(pc_b), .m_int_addr(m_int_addr),
    .m_int_byteen(m_int_byteen), .interrupt(int_b), .fire_count(fc_b),
    .active_slot(as_b), .dbg_state(st_b)
`ifdef INT_INJ_TIMEOUT_EN
    , .timeout_err()
`endif
  );

  // C: two slots on the same address 0x3040.
  int_injector #(.NUM_TRIG(2), .TRIG_PCS({32'h0000_3040, 32'h0000_3040}),
                 .TRIG_CNT({4'd1, 4'd1})) u_c (
    .clk(clk), .reset(reset), .macroscopic_pc(pc_c), .m_int_addr(m_int_addr),
    .m_int_byteen(m_int_byteen), .interrupt(int_c), .fire_count(fc_c),
    .active_slot(as_c), .dbg_state(st_c)
`ifdef INT_INJ_TIMEOUT_EN
    , .timeout_err()
`endif
  );

  // D: pulse mode, three firings, cooldown 2.
  int_injector #(.NUM_TRIG(1), .TRIG_PCS(32'h0000_302C), .TRIG_CNT(4'd3),
                 .PULSE_MODE(1), .COOLDOWN(2)) u_d (
    .clk(clk), .reset(reset), .macroscopic_pc(pc_d), .m_int_addr(m_int_addr),
    .m_int_byteen(m_int_byteen), .interrupt(int_d), .fire_count(fc_d),
    .active_slot(as_d), .dbg_state(st_d)
`ifdef INT_INJ_TIMEOUT_EN
    , .timeout_err()
`endif
  );

  // E: default parameters (four slots, all at 0x302C).
`ifdef INT_INJ_TIMEOUT_EN
  logic terr_e;
  int_injector #(.ACK_TIMEOUT(8)) u_e (
    .clk(clk), .reset(reset), .macroscopic_pc(pc_e), .m_int_addr(m_int_addr),
    .m_int_byteen(m_int_byteen), .interrupt(int_e), .fire_count(fc_e),
    .active_slot(as_e), .dbg_state(st_e), .timeout_err(terr_e)
  );
`else
  int_injector u_e (
    .clk(clk), .reset(reset), .macroscopic_pc(pc_e), .m_int_addr(m_int_addr),
    .m_int_byteen(m_int_byteen), .interrupt(int_e), .fire_count(fc_e),
    .active_slot(as_e), .dbg_state(st_e)
  );
`endif

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_on(input logic [31:0] addr, input logic [3:0] be);
    m_int_addr   = addr;
    m_int_byteen = be;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    checks++;
    if ({int_a, int_b, int_c, int_d, int_e} !== 5'b0) begin
      errors++;
      $display("FAIL reset_interrupt: got %b expected 00000", {int_a, int_b, int_c, int_d, int_e});
    end
    checks++;
    if ({fc_a, fc_b, fc_e} !== 24'h0) begin
      errors++;
      $display("FAIL reset_fire_count: got %h expected 000000", {fc_a, fc_b, fc_e});
    end
    checks++;
    if ({as_b, as_e, st_a, st_e} !== 12'h0) begin
      errors++;
      $display("FAIL reset_slot_state: got %h expected 000", {as_b, as_e, st_a, st_e});
    end
`ifdef INT_INJ_TIMEOUT_EN
    checks++;
    if (terr_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout_err: got %b expected 0", terr_e);
    end
`endif
  endtask

  task automatic test_level_ack();
    pc_a = 32'h0000_302C;
    step();
    pc_a = 32'h0000_3030;
    checks++;
    if ({int_a, fc_a, as_a} !== {1'b1, 8'd1, 4'd0}) begin
      errors++;
      $display("FAIL level_rise: got int=%b fc=%0d slot=%0d expected int=1 fc=1 slot=0", int_a, fc_a, as_a);
    end
    step(2);
    checks++;
    if (int_a !== 1'b1) begin
      errors++;
      $display("FAIL level_hold: got %b expected 1", int_a);
    end
    ack_on(32'h0000_7F20, 4'b0001);
    step();
    ack_on(32'h0, 4'b0000);
    checks++;
    if (int_a !== 1'b0) begin
      errors++;
      $display("FAIL level_ack_fall: got %b expected 0", int_a);
    end
    step(3);
    pc_a = 32'h0000_302C;
    step(2);
    pc_a = 32'h0;
    checks++;
    if ({int_a, fc_a} !== {1'b0, 8'd1}) begin
      errors++;
      $display("FAIL level_second_visit: got int=%b fc=%0d expected int=0 fc=1", int_a, fc_a);
    end
  endtask

  task automatic test_multi_slot();
    logic [3:0] exp_slot;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 2; s++) begin
        exp_slot = 4'(s);
        // Low address bits are set on purpose; the compare must mask them.
        pc_b = (s == 0) ? 32'h0000_3013 : 32'h0000_3021;
        step();
        pc_b = 32'h0;
        checks++;
        if ({int_b, as_b, fc_b} !== {1'b1, exp_slot, 8'(r * 2 + s + 1)}) begin
          errors++;
          $display("FAIL multi_fire r%0d s%0d: got int=%b slot=%0d fc=%0d expected int=1 slot=%0d fc=%0d",
                   r, s, int_b, as_b, fc_b, exp_slot, r * 2 + s + 1);
        end
        ack_on(32'h0000_7F20, 4'b1111);
        step();
        ack_on(32'h0, 4'b0000);
        checks++;
        if (int_b !== 1'b0) begin
          errors++;
          $display("FAIL multi_ack r%0d s%0d: got %b expected 0", r, s, int_b);
        end
        step(3);
      end
    end
    pc_b = 32'h0000_3010;
    step(2);
    pc_b = 32'h0000_3020;
    step(2);
    pc_b = 32'h0;
    checks++;
    if ({int_b, fc_b} !== {1'b0, 8'd4}) begin
      errors++;
      $display("FAIL multi_exhausted: got int=%b fc=%0d expected int=0 fc=4", int_b, fc_b);
    end
  endtask

  task automatic test_priority();
    pc_c = 32'h0000_3040;
    step();
    checks++;
    if ({int_c, as_c, fc_c} !== {1'b1, 4'd0, 8'd1}) begin
      errors++;
      $display("FAIL prio_first: got int=%b slot=%0d fc=%0d expected int=1 slot=0 fc=1", int_c, as_c, fc_c);
    end
    ack_on(32'h0000_7F20, 4'b0010);
    step();
    ack_on(32'h0, 4'b0000);
    // PC stays on the target: two cooldown cycles, one IDLE cycle, then slot 1.
    step(2);
    checks++;
    if (int_c !== 1'b0) begin
      errors++;
      $display("FAIL prio_cooldown: got %b expected 0", int_c);
    end
    step();
    checks++;
    if ({int_c, as_c, fc_c} !== {1'b1, 4'd1, 8'd2}) begin
      errors++;
      $display("FAIL prio_second: got int=%b slot=%0d fc=%0d expected int=1 slot=1 fc=2", int_c, as_c, fc_c);
    end
    ack_on(32'h0000_7F20, 4'b0100);
    step();
    ack_on(32'h0, 4'b0000);
    step(5);
    pc_c = 32'h0;
    checks++;
    if ({int_c, fc_c} !== {1'b0, 8'd2}) begin
      errors++;
      $display("FAIL prio_exhausted: got int=%b fc=%0d expected int=0 fc=2", int_c, fc_c);
    end
  endtask

  task automatic test_pulse();
    logic exp_int;
    ack_on(32'h0000_7F20, 4'b0001);
    pc_d = 32'h0000_302C;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 10) pc_d = 32'h0;
      exp_int = (i == 1) || (i == 5) || (i == 9);
      checks++;
      if (int_d !== exp_int) begin
        errors++;
        $display("FAIL pulse_cycle%0d: got %b expected %b", i, int_d, exp_int);
      end
    end
    ack_on(32'h0, 4'b0000);
    checks++;
    if ({fc_d, as_d} !== {8'd3, 4'd0}) begin
      errors++;
      $display("FAIL pulse_count: got fc=%0d slot=%0d expected fc=3 slot=0", fc_d, as_d);
    end
  endtask

  task automatic test_bad_ack_and_reset();
    pc_e = 32'h0000_302C;
    step();
    pc_e = 32'h0;
    ack_on(32'h0000_7F24, 4'b1111);
    step();
    checks++;
    if (int_e !== 1'b1) begin
      errors++;
      $display("FAIL bad_ack_addr: got %b expected 1", int_e);
    end
    ack_on(32'h0000_7F20, 4'b0000);
    step();
    ack_on(32'h0, 4'b0000);
    checks++;
    if ({int_e, as_e, fc_e} !== {1'b1, 4'd0, 8'd1}) begin
      errors++;
      $display("FAIL bad_ack_byteen: got int=%b slot=%0d fc=%0d expected int=1 slot=0 fc=1", int_e, as_e, fc_e);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({int_e, fc_e} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_assert: got int=%b fc=%0d expected int=0 fc=0", int_e, fc_e);
    end
    // Slot 0 only wins again if its remaining count was reloaded.
    pc_e = 32'h0000_302C;
    step();
    pc_e = 32'h0;
    checks++;
    if ({int_e, as_e, fc_e} !== {1'b1, 4'd0, 8'd1}) begin
      errors++;
      $display("FAIL reset_reload: got int=%b slot=%0d fc=%0d expected int=1 slot=0 fc=1", int_e, as_e, fc_e);
    end
    ack_on(32'h0000_7F23, 4'b1000);
    step();
    ack_on(32'h0, 4'b0000);
    checks++;
    if (int_e !== 1'b0) begin
      errors++;
      $display("FAIL masked_ack: got %b expected 0", int_e);
    end
    step(3);
  endtask

`ifdef INT_INJ_TIMEOUT_EN
  task automatic test_timeout();
    pc_e = 32'h0000_302C;
    step();
    pc_e = 32'h0;
    for (int i = 2; i <= 8; i++) begin
      step();
      checks++;
      if (int_e !== 1'b1) begin
        errors++;
        $display("FAIL timeout_hold%0d: got %b expected 1", i, int_e);
      end
    end
    step();
    checks++;
    if ({int_e, terr_e} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_fire: got int=%b err=%b expected int=0 err=1", int_e, terr_e);
    end
    step(5);
    checks++;
    if (terr_e !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %b expected 1", terr_e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_level_ack();
    test_multi_slot();
    test_priority();
    test_pulse();
    test_bad_ack_and_reset();
`ifdef INT_INJ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_injector.md
Name: int_injector

Overview:
Interrupt stimulus generator for CPU-level benches of the pipelined MIPS core. Watches the macroscopic PC and raises the external interrupt line when the PC matches one of NUM_TRIG programmed target addresses. Each target fires a configurable number of times. The line is released by an interrupt-controller acknowledge store, or pulsed for one cycle in pulse mode. Sits beside the CPU top in the testbench and drives the CPU's interrupt input.

Parameters:
NUM_TRIG, 4, number of independent target-PC slots (1..16)
TRIG_PCS, {NUM_TRIG{32'h0000302C}}, packed NUM_TRIG*32 vector; slot k occupies bits [32k+31:32k]
TRIG_CNT, {NUM_TRIG{4'd1}}, packed NUM_TRIG*4 vector; number of firings allowed per slot; 0 disables the slot
ACK_ADDR, 32'h00007F20, word address whose store acknowledges the interrupt
PULSE_MODE, 0, 0 = level (hold until ack); 1 = single-cycle pulse, ack ignored
COOLDOWN, 2, idle cycles enforced after release before the next match is accepted (0..255)

Ports:
clk  input  1  bench clock; all state updates on posedge
reset  input  1  synchronous, active-high
macroscopic_pc  input  32  CPU macroscopic PC; low 2 bits masked before compare
m_int_addr  input  32  interrupt-controller store address; low 2 bits masked
m_int_byteen  input  4  store byte enables; ack requires any bit set
interrupt  output  1  interrupt request to the CPU, registered
fire_count  output  8  total assertions since reset, saturating at 255
active_slot  output  4  index of the slot that caused the current or last assertion

Behaviour:
- Reset: interrupt=0, fire_count=0, active_slot=0, state=IDLE. Per-slot remaining counters load from TRIG_CNT. Reset mid-ASSERT drops interrupt on the next edge.
- Match: slot k hits when (macroscopic_pc & ~3) == TRIG_PCS[k] and remaining[k] != 0. If several slots hit in the same cycle, the lowest index wins; the others keep their counts.
- FSM:
  - IDLE: on a hit, go to ASSERT. interrupt=1 from the next cycle (1-cycle latency). Decrement remaining[winner], set active_slot=winner, increment fire_count.
  - ASSERT, level mode: stay while no ack. Ack = |m_int_byteen && (m_int_addr & ~3) == ACK_ADDR. On ack, interrupt=0 next edge and go to COOLDOWN.
  - ASSERT, pulse mode: interrupt high for exactly 1 cycle, then COOLDOWN unconditionally.
  - COOLDOWN: count COOLDOWN cycles; matches are ignored and not counted. Then return to IDLE. COOLDOWN=0 means return to IDLE next cycle.
- A PC that sits on a target for many cycles fires once per IDLE entry, subject to remaining counts.
- An ack seen in IDLE or COOLDOWN is ignored.
- Simultaneous hit and ack in ASSERT: the ack is processed and the hit is dropped.
- fire_count saturates at 255 and does not wrap.

Optional Feature:
INT_INJ_TIMEOUT_EN:
- Defined: adds parameter ACK_TIMEOUT (default 1024). If ASSERT lasts ACK_TIMEOUT cycles in level mode without an ack, force interrupt=0, go to COOLDOWN, and set a sticky output timeout_err=1 (cleared only by reset).
- Undefined: no counter and no timeout_err port. ASSERT holds indefinitely.

Decomposition:
- Shared package int_inj_pkg:
  - state enum {IDLE, ASSERT, COOLDOWN}
  - ACK_ADDR default constant
  - PC_MASK = 32'hFFFFFFFC
  - width constants for fire_count and slot index
- One sub-module, int_trig_match: combinational compare of PC against all slots with remaining counts, plus lowest-index priority encoder. Outputs hit and winner index.

Test Plan:
- Default params, PC reaches 0x302C, ack store at 0x7F20 byteen=4'b0001 three cycles later -> interrupt rises 1 cycle after match, falls 1 cycle after ack; fire_count=1. A second visit to 0x302C does not fire.
- Slots 0x3010/0x3020, TRIG_CNT=2 each, PC loops over both with prompt acks -> exactly 4 assertions; active_slot sequence 0,1,0,1; fire_count=4.
- Two slots both at 0x3040 -> slot 0 wins the first firing; the next visit after COOLDOWN fires slot 1.
- PULSE_MODE=1, PC held at 0x302C for 10 cycles, COOLDOWN=2, TRIG_CNT=3 -> three 1-cycle pulses spaced 4 cycles apart; acks are ignored.
- Store to 0x7F24, or byteen=0 at 0x7F20, during ASSERT -> interrupt stays high. Reset asserted during ASSERT -> interrupt=0 and counters reloaded next edge.
- INT_INJ_TIMEOUT_EN with ACK_TIMEOUT=8 and no ack -> interrupt falls after 8 cycles high; timeout_err=1 and stays set.
